// File: rtl/cpu7_mem_arb_pkg.sv
// rtl/cpu7_mem_arb_pkg.sv - shared encodings and width helpers for the memory-port arbiter
package cpu7_mem_arb_pkg;

  // FIFO entry layout is {id, we}; the we bit doubles as the expected response type.
  typedef enum logic {
    RSP_READ  = 1'b0,
    RSP_WRITE = 1'b1
  } rsp_type_e;

  function automatic int id_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cpu7_mem_arb_id_fifo.sv
// rtl/cpu7_mem_arb_id_fifo.sv - in-order tracker of issued {id, we} entries
module cpu7_mem_arb_id_fifo
  import cpu7_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    if (push_i) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (do_pop) rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/cpu7_mem_arb.sv
// rtl/cpu7_mem_arb.sv - round-robin N-channel arbiter onto one in-order downstream memory port
module cpu7_mem_arb
  import cpu7_mem_arb_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OUTST = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NCH-1:0]        ch_req_i,
  input  logic [NCH-1:0]        ch_we_i,
  input  logic [NCH*AW-1:0]     ch_addr_i,
  input  logic [NCH*DW-1:0]     ch_wdata_i,
  input  logic [NCH*DW/8-1:0]   ch_strb_i,
  output logic [NCH-1:0]        ch_ack_o,
  output logic [NCH-1:0]        ch_rvalid_o,
  output logic [DW-1:0]         ch_rdata_o,
  output logic [NCH-1:0]        ch_wdone_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DW-1:0]         mem_wdata_o,
  output logic [DW/8-1:0]       mem_strb_o,
  input  logic                  mem_ack_i,
  input  logic                  mem_rvalid_i,
  input  logic [DW-1:0]         mem_rdata_i,
  input  logic                  mem_wdone_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int IDW = id_width(NCH);
  localparam int SW  = DW / 8;
  localparam int CW  = cnt_width(OUTST);

  logic           slot_v_q, slot_v_d;
  logic [IDW-1:0] slot_id_q, slot_id_d;
  logic           slot_we_q, slot_we_d;
  logic [AW-1:0]  slot_addr_q, slot_addr_d;
  logic [DW-1:0]  slot_wdata_q, slot_wdata_d;
  logic [SW-1:0]  slot_strb_q, slot_strb_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic           err_q, err_d;

  logic [IDW-1:0] grant;
  logic           any_req, xfer, can_fill, accept;
  logic           rsp_any, pop, mismatch;
  logic [IDW:0]   fifo_head;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_empty;
  logic [IDW-1:0] head_id;
  rsp_type_e      head_type;

  // First requester at or after rr_q, wrapping.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && ch_req_i[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // Credit counts the slot as already outstanding; a same-cycle pop frees nothing until next cycle.
  assign any_req  = |ch_req_i;
  assign xfer     = slot_v_q & mem_ack_i;
  assign can_fill = (~slot_v_q | xfer) & ((int'(fifo_cnt) + int'(slot_v_q)) < OUTST);
  assign accept   = can_fill & any_req & ~reset_i;
  assign ch_ack_o = accept ? (NCH'(1) << grant) : '0;

  always_comb begin
    slot_v_d     = slot_v_q;
    slot_id_d    = slot_id_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_strb_d  = slot_strb_q;
    rr_d         = rr_q;
    if (accept) begin
      slot_v_d     = 1'b1;
      slot_id_d    = grant;
      slot_we_d    = ch_we_i[grant];
      slot_addr_d  = ch_addr_i[int'(grant)*AW +: AW];
      slot_wdata_d = ch_wdata_i[int'(grant)*DW +: DW];
      slot_strb_d  = ch_strb_i[int'(grant)*SW +: SW];
      rr_d         = (int'(grant) == NCH - 1) ? '0 : grant + IDW'(1);
    end else if (xfer) begin
      slot_v_d = 1'b0;
    end
  end

  assign mem_req_o   = slot_v_q;
  assign mem_we_o    = slot_we_q;
  assign mem_addr_o  = slot_addr_q;
  assign mem_wdata_o = slot_wdata_q;
  assign mem_strb_o  = slot_strb_q;

  cpu7_mem_arb_id_fifo #(
    .DEPTH (OUTST),
    .W     (IDW + 1)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (reset_i),
    .push_i      (xfer),
    .push_data_i ({slot_id_q, slot_we_q}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty)
  );

  // Responses route by the FIFO head; rvalid takes priority when both strobes fire.
  assign head_id     = fifo_head[IDW:1];
  assign head_type   = rsp_type_e'(fifo_head[0]);
  assign rsp_any     = mem_rvalid_i | mem_wdone_i;
  assign pop         = rsp_any & ~fifo_empty;
  assign mismatch    = mem_rvalid_i ? (head_type == RSP_WRITE) : (head_type == RSP_READ);
  assign ch_rvalid_o = (mem_rvalid_i & ~fifo_empty) ? (NCH'(1) << head_id) : '0;
  assign ch_wdone_o  = (mem_wdone_i & ~mem_rvalid_i & ~fifo_empty) ? (NCH'(1) << head_id) : '0;
  assign ch_rdata_o  = mem_rdata_i;
  assign busy_o      = slot_v_q | ~fifo_empty;
  assign err_o       = err_q;

  always_comb begin
    err_d = err_q;
    if (rsp_any & fifo_empty)        err_d = 1'b1;
    if (mem_rvalid_i & mem_wdone_i)  err_d = 1'b1;
    if (pop & mismatch)              err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_v_q     <= 1'b0;
      slot_id_q    <= '0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_strb_q  <= '0;
      rr_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_v_q     <= slot_v_d;
      slot_id_q    <= slot_id_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_strb_q  <= slot_strb_d;
      rr_q         <= rr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu7_mem_arb.sv
// tb/tb_cpu7_mem_arb.sv - self-checking bench for cpu7_mem_arb
module tb_cpu7_mem_arb;

  localparam int NCH   = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int OUTST = 4;
  localparam int SW    = DW / 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      ch_req, ch_we;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*DW-1:0]   ch_wdata;
  logic [NCH*SW-1:0]   ch_strb;
  logic [NCH-1:0]      ch_ack, ch_rvalid, ch_wdone;
  logic [DW-1:0]       ch_rdata;
  logic                mem_req, mem_we, mem_ack, mem_rvalid, mem_wdone;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata, mem_rdata;
  logic [SW-1:0]       mem_strb;
  logic                busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu7_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST)) dut (
    .clk_i(clk), .reset_i(reset),
    .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_addr_i(ch_addr),
    .ch_wdata_i(ch_wdata), .ch_strb_i(ch_strb),
    .ch_ack_o(ch_ack), .ch_rvalid_o(ch_rvalid), .ch_rdata_o(ch_rdata), .ch_wdone_o(ch_wdone),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_wdone_i(mem_wdone),
    .busy_o(busy), .err_o(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending-request record plus a queue of outstanding transactions.
  typedef struct {
    int             id;
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  strb;
  } txn_t;

  txn_t m_slot;
  bit   m_slot_v = 0;
  txn_t m_q[$];
  int   m_rr = 0;
  bit   m_err = 0;

  always @(negedge clk) begin
    logic [NCH-1:0] e_ack, e_rv, e_wd;
    int  g, c, occ;
    bit  xfer, can;
    e_ack = '0; e_rv = '0; e_wd = '0; g = -1; c = 0;
    if (reset) begin
      check("m_rst_ack", ch_ack, 0);
      check("m_rst_memreq", mem_req, 0);
      check("m_rst_busy", busy, 0);
      check("m_rst_err", err, 0);
      m_slot_v = 0; m_q.delete(); m_rr = 0; m_err = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        c = (m_rr + i) % NCH;
        if (g < 0 && ch_req[c]) g = c;
      end
      xfer = m_slot_v && mem_ack;
      occ  = m_q.size() + (m_slot_v ? 1 : 0);
      can  = (!m_slot_v || xfer) && (occ < OUTST);
      if (can && g >= 0) e_ack[g] = 1'b1;
      if (m_q.size() > 0) begin
        if (mem_rvalid) e_rv[m_q[0].id] = 1'b1;
        else if (mem_wdone) e_wd[m_q[0].id] = 1'b1;
      end
      check("m_ack", ch_ack, e_ack);
      check("m_rvalid", ch_rvalid, e_rv);
      check("m_wdone", ch_wdone, e_wd);
      check("m_memreq", mem_req, m_slot_v);
      check("m_busy", busy, (m_slot_v || m_q.size() > 0));
      check("m_err", err, m_err);
      if (m_slot_v) begin
        check("m_we", mem_we, m_slot.we);
        check("m_addr", mem_addr, m_slot.addr);
        check("m_wdata", mem_wdata, m_slot.wdata);
        check("m_strb", mem_strb, m_slot.strb);
      end
      if (mem_rvalid || mem_wdone) begin
        if (m_q.size() == 0) m_err = 1;
        else begin
          if (mem_rvalid && mem_wdone) m_err = 1;
          if (mem_rvalid ? m_q[0].we : !m_q[0].we) m_err = 1;
          void'(m_q.pop_front());
        end
      end
      if (xfer) begin
        m_q.push_back(m_slot);
        m_slot_v = 0;
      end
      if (g >= 0 && can) begin
        m_slot.id    = g;
        m_slot.we    = ch_we[g];
        m_slot.addr  = ch_addr[g*AW +: AW];
        m_slot.wdata = ch_wdata[g*DW +: DW];
        m_slot.strb  = ch_strb[g*SW +: SW];
        m_slot_v     = 1;
        m_rr         = (g + 1) % NCH;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input bit req, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
    ch_req[c]          = req;
    ch_we[c]           = we;
    ch_addr[c*AW +: AW]  = a;
    ch_wdata[c*DW +: DW] = d;
    ch_strb[c*SW +: SW]  = s;
  endtask

  task automatic idle();
    ch_req = '0; mem_ack = 0; mem_rvalid = 0; mem_wdone = 0;
  endtask

  task automatic rst_pulse();
    step();
    reset = 1; idle();
    step();
    reset = 0;
    step();
  endtask

  initial begin
    logic [NCH-1:0] order [6];
    int acks;
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset = 1; ch_we = '0; ch_addr = '0; ch_wdata = '0; ch_strb = '0;
    mem_rdata = '0; idle();
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_memreq", mem_req, 0);
    reset = 0;
    step();

    // 1: single read on ch1
    set_ch(1, 1, 0, 32'h1c000010, 0, 0); #1;
    check("t1_ack", ch_ack, 3'b010);
    step(); set_ch(1, 0, 0, 32'h1c000010, 0, 0); #1;
    check("t1_memreq", mem_req, 1);
    check("t1_memaddr", mem_addr, 32'h1c000010);
    step(); mem_ack = 1;
    step(); mem_ack = 0;
    step();
    step(); mem_rvalid = 1; mem_rdata = 32'hdeadbeef; #1;
    check("t1_rvalid", ch_rvalid, 3'b010);
    check("t1_rdata", ch_rdata, 32'hdeadbeef);
    step(); mem_rvalid = 0;

    // 2: all channels, round-robin, one transfer per cycle
    rst_pulse();
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, (k < 6), 0, 32'h1000 + c*16, 0, 0);
      mem_ack = 1; mem_rvalid = (k >= 2 && k <= 7); mem_rdata = k; #1;
      if (k < 6) check("t2_order", ch_ack, order[k]);
      if (k >= 1 && k <= 6) check("t2_memreq", mem_req, 1);
      step();
    end
    idle();

    // 3: credit limit
    rst_pulse();
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      set_ch(0, 1, 0, 32'h2000 + k, 0, 0);
      mem_ack = 1; mem_rvalid = (k == 8); #1;
      if (k < 8) acks += int'(ch_ack[0]);
      if (k == 7) check("t3_memreq_idle", mem_req, 0);
      if (k == 8) check("t3_no_bypass", ch_ack, 3'b000);
      if (k == 9) check("t3_ack_after_pop", ch_ack, 3'b001);
      step();
    end
    idle();
    check("t3_ack_count", acks, 4);

    // 4: stalled downstream holds the slot
    rst_pulse();
    set_ch(1, 1, 1, 32'h100, 32'h11223344, 4'b1010); #1;
    check("t4_ack", ch_ack, 3'b010);
    step();
    for (int k = 1; k <= 5; k++) begin
      set_ch(1, 0, 1, 32'h100, 32'h11223344, 4'b1010);
      set_ch(0, 1, 0, 32'h200, 32'h0, 4'hf);
      mem_ack = 0; #1;
      check("t4_noack", ch_ack, 3'b000);
      check("t4_addr", mem_addr, 32'h100);
      check("t4_wdata", mem_wdata, 32'h11223344);
      check("t4_strb", mem_strb, 4'b1010);
      step();
    end
    mem_ack = 1; #1;
    check("t4_refill_ack", ch_ack, 3'b001);
    step(); set_ch(0, 0, 0, 32'h200, 0, 4'hf); #1;
    check("t4_addr2", mem_addr, 32'h200);
    step(); mem_ack = 0; mem_wdone = 1; #1;
    check("t4_wdone", ch_wdone, 3'b010);
    step(); mem_wdone = 0; mem_rvalid = 1; mem_rdata = 32'h0badf00d; #1;
    check("t4_rvalid", ch_rvalid, 3'b001);
    step(); idle();

    // 5: write ch2 then read ch0, responses in issue order
    rst_pulse();
    set_ch(2, 1, 1, 32'h300, 32'hcafef00d, 4'hf); #1;
    check("t5_ack_w", ch_ack, 3'b100);
    step(); set_ch(2, 0, 1, 32'h300, 32'hcafef00d, 4'hf);
    set_ch(0, 1, 0, 32'h400, 0, 0); mem_ack = 1; #1;
    check("t5_ack_r", ch_ack, 3'b001);
    step(); set_ch(0, 0, 0, 32'h400, 0, 0); mem_ack = 1;
    step(); mem_ack = 0; mem_wdone = 1; #1;
    check("t5_wdone", ch_wdone, 3'b100);
    check("t5_no_rvalid", ch_rvalid, 3'b000);
    step(); mem_wdone = 0; mem_rvalid = 1; mem_rdata = 32'h5a5a5a5a; #1;
    check("t5_rvalid", ch_rvalid, 3'b001);
    check("t5_rdata", ch_rdata, 32'h5a5a5a5a);
    step(); idle();

    // 6: stray response, sticky err, reset mid-burst
    mem_wdone = 1;
    step(); mem_wdone = 0; #1;
    check("t6_err", err, 1);
    step(); #1;
    check("t6_err_sticky", err, 1);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, 1, c[0], 32'h500 + c, 32'h77, 4'h3);
      mem_ack = 1;
      step();
    end
    reset = 1; idle(); #1;
    check("t6_rst_memreq", mem_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err, 0);
    step(); #1;
    check("t6_rst_busy_edge", busy, 0);
    reset = 0;
    step(); mem_rvalid = 1;
    step(); mem_rvalid = 0; #1;
    check("t6_stray_err", err, 1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
